// File: rtl/wb_retire_pkg.sv
// Shared core definitions used by the writeback/retire stage.
// Holds the load funct3 encodings and the default datapath width.
package wb_retire_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

endpackage

// File: rtl/wb_retire_if.sv
// MEM/WB-to-writeback bundle: pipeline control/data in, register-file write,
// commit trace and retire counters out.
interface wb_retire_if
  import wb_retire_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 64,
  parameter int EVT_W = 32
);
  logic             i_stall;
  logic             i_cnt_clr;
  logic [XLEN-1:0]  i_pc;
  logic [XLEN-1:0]  i_alu_result;
  logic [XLEN-1:0]  i_rdata;
  logic [4:0]       i_rd;
  logic             i_ctrl_valid;
  logic             i_ctrl_bubble;
  logic             i_ctrl_wb_en;
  logic             i_ctrl_mem_read;
  logic             i_ctrl_mispred;
  logic             i_ctrl_is_control;
  logic [2:0]       i_ctrl_funct3;

  logic             o_rf_we;
  logic [4:0]       o_rf_waddr;
  logic [XLEN-1:0]  o_rf_wdata;
  logic             o_commit_valid;
  logic [XLEN-1:0]  o_commit_pc;
  logic [XLEN-1:0]  o_commit_wdata;
  logic [4:0]       o_commit_rd;
  logic [CNT_W-1:0] o_cycle;
  logic [CNT_W-1:0] o_instret;
  logic [EVT_W-1:0] o_ctrl_cnt;
  logic [EVT_W-1:0] o_mispred_cnt;

  modport master (
    output i_stall, i_cnt_clr, i_pc, i_alu_result, i_rdata, i_rd,
           i_ctrl_valid, i_ctrl_bubble, i_ctrl_wb_en, i_ctrl_mem_read,
           i_ctrl_mispred, i_ctrl_is_control, i_ctrl_funct3,
    input  o_rf_we, o_rf_waddr, o_rf_wdata, o_commit_valid, o_commit_pc,
           o_commit_wdata, o_commit_rd, o_cycle, o_instret, o_ctrl_cnt,
           o_mispred_cnt
  );

  modport slave (
    input  i_stall, i_cnt_clr, i_pc, i_alu_result, i_rdata, i_rd,
           i_ctrl_valid, i_ctrl_bubble, i_ctrl_wb_en, i_ctrl_mem_read,
           i_ctrl_mispred, i_ctrl_is_control, i_ctrl_funct3,
    output o_rf_we, o_rf_waddr, o_rf_wdata, o_commit_valid, o_commit_pc,
           o_commit_wdata, o_commit_rd, o_cycle, o_instret, o_ctrl_cnt,
           o_mispred_cnt
  );
endinterface

// File: rtl/wb_load_align.sv
// Combinational load formatter: picks the byte/halfword addressed by the low
// address bits out of the aligned DMEM word and sign- or zero-extends it.
module wb_load_align
  import wb_retire_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_off,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    // off[0] is deliberately ignored: misaligned halfwords trap upstream
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
      F3_LW:   o_data = i_word;
      default: o_data = i_word;
    endcase
  end
endmodule

// File: rtl/wb_retire.sv
// Writeback/retire stage: result select and register-file write port, plus
// architectural retire counters and a one-cycle-delayed commit trace.
module wb_retire
  import wb_retire_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 64,
  parameter int EVT_W = 32
) (
  input logic       i_clk,
  input logic       i_reset,
  wb_retire_if.slave bus
);
  logic            w_retire;
  logic            w_count;
  logic            w_rf_we;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_result;
  logic [4:0]      w_waddr;
  logic [XLEN-1:0] w_wdata;

  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;
  logic [EVT_W-1:0] r_ctrl_cnt;
  logic [EVT_W-1:0] r_mispred_cnt;
  logic             r_commit_valid;
  logic [XLEN-1:0]  r_commit_pc;
  logic [XLEN-1:0]  r_commit_wdata;
  logic [4:0]       r_commit_rd;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .i_word   (bus.i_rdata),
    .i_off    (bus.i_alu_result[1:0]),
    .i_funct3 (bus.i_ctrl_funct3),
    .o_data   (w_load)
  );

  // A stalled instruction may still write (idempotent) but is counted only once
  assign w_retire = bus.i_ctrl_valid && !bus.i_ctrl_bubble;
  assign w_count  = w_retire && !bus.i_stall;
  assign w_result = bus.i_ctrl_mem_read ? w_load : bus.i_alu_result;
  assign w_rf_we  = w_retire && bus.i_ctrl_wb_en && (bus.i_rd != 5'd0);
  assign w_waddr  = w_rf_we ? bus.i_rd : 5'd0;
  assign w_wdata  = w_rf_we ? w_result : '0;

  assign bus.o_rf_we    = w_rf_we;
  assign bus.o_rf_waddr = w_waddr;
  assign bus.o_rf_wdata = w_wdata;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cycle       <= '0;
      r_instret     <= '0;
      r_ctrl_cnt    <= '0;
      r_mispred_cnt <= '0;
    end else if (bus.i_cnt_clr) begin
      r_cycle       <= '0;
      r_instret     <= '0;
      r_ctrl_cnt    <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
      if (w_count) begin
        r_instret <= r_instret + 1'b1;
        if (bus.i_ctrl_is_control) r_ctrl_cnt <= r_ctrl_cnt + 1'b1;
        if (bus.i_ctrl_mispred)    r_mispred_cnt <= r_mispred_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_commit_valid <= 1'b0;
      r_commit_pc    <= '0;
      r_commit_wdata <= '0;
      r_commit_rd    <= 5'd0;
    end else begin
      r_commit_valid <= w_count;
      if (w_count) begin
        r_commit_pc    <= bus.i_pc;
        r_commit_wdata <= w_wdata;
        r_commit_rd    <= w_waddr;
      end
    end
  end

  assign bus.o_commit_valid = r_commit_valid;
  assign bus.o_commit_pc    = r_commit_pc;
  assign bus.o_commit_wdata = r_commit_wdata;
  assign bus.o_commit_rd    = r_commit_rd;
  assign bus.o_cycle        = r_cycle;
  assign bus.o_instret      = r_instret;
  assign bus.o_ctrl_cnt     = r_ctrl_cnt;
  assign bus.o_mispred_cnt  = r_mispred_cnt;
endmodule

// File: tb/tb_wb_retire.sv
// Directed plus randomized bench for wb_retire against an arithmetic
// reference model of load formatting, counters and the commit trace.
module tb_wb_retire;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;

  logic [63:0] m_cycle;
  logic [63:0] m_instret;
  logic [31:0] m_ctrl;
  logic [31:0] m_misp;
  logic        m_cv;
  logic [31:0] m_cpc;
  logic [31:0] m_cwd;
  logic [4:0]  m_crd;

  wb_retire_if #(.XLEN(32), .CNT_W(64), .EVT_W(32)) bus ();

  wb_retire #(.XLEN(32), .CNT_W(64), .EVT_W(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load value computed from shifts and two's-complement arithmetic
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] b;
    logic [31:0] h;
    int          hsel;
    b = (w >> (8 * off)) & 32'd255;
    hsel = off[1] ? 16 : 0;
    h = (w >> hsel) & 32'd65535;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic model_zero();
    m_cycle = 0; m_instret = 0; m_ctrl = 0; m_misp = 0;
    m_cv = 0; m_cpc = 0; m_cwd = 0; m_crd = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".commit_valid"}, 64'(bus.o_commit_valid), 64'(m_cv));
    check({tag, ".commit_pc"}, 64'(bus.o_commit_pc), 64'(m_cpc));
    check({tag, ".commit_rd"}, 64'(bus.o_commit_rd), 64'(m_crd));
    check({tag, ".commit_wdata"}, 64'(bus.o_commit_wdata), 64'(m_cwd));
    check({tag, ".cycle"}, bus.o_cycle, m_cycle);
    check({tag, ".instret"}, bus.o_instret, m_instret);
    check({tag, ".ctrl_cnt"}, 64'(bus.o_ctrl_cnt), 64'(m_ctrl));
    check({tag, ".mispred_cnt"}, 64'(bus.o_mispred_cnt), 64'(m_misp));
  endtask

  // Called at a falling edge: drive, check the write port, clock, check state
  task automatic apply(input string tag, input logic valid, input logic bubble,
                       input logic wb_en, input logic mem_read, input logic misp,
                       input logic is_ctrl, input logic stall, input logic clr,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] rdata);
    logic        retire, count, we;
    logic [31:0] wd;
    bus.i_ctrl_valid = valid;     bus.i_ctrl_bubble = bubble;
    bus.i_ctrl_wb_en = wb_en;     bus.i_ctrl_mem_read = mem_read;
    bus.i_ctrl_mispred = misp;    bus.i_ctrl_is_control = is_ctrl;
    bus.i_stall = stall;          bus.i_cnt_clr = clr;
    bus.i_ctrl_funct3 = f3;       bus.i_rd = rd;
    bus.i_pc = pc;                bus.i_alu_result = alu;
    bus.i_rdata = rdata;
    #1;
    retire = valid && !bubble;
    count  = retire && !stall;
    we     = retire && wb_en && (rd != 0);
    wd     = we ? (mem_read ? model_load(rdata, alu[1:0], f3) : alu) : 32'd0;
    check({tag, ".rf_we"}, 64'(bus.o_rf_we), 64'(we));
    check({tag, ".rf_waddr"}, 64'(bus.o_rf_waddr), 64'(we ? rd : 5'd0));
    check({tag, ".rf_wdata"}, 64'(bus.o_rf_wdata), 64'(wd));
    if (count && misp && !is_ctrl)
      $display("note %s: mispredict retired without is_control", tag);
    @(posedge clk);
    if (clr) begin
      m_cycle = 0; m_instret = 0; m_ctrl = 0; m_misp = 0;
    end else begin
      m_cycle++;
      if (count) begin
        m_instret++;
        if (is_ctrl) m_ctrl++;
        if (misp) m_misp++;
      end
    end
    m_cv = count;
    if (count) begin
      m_cpc = pc; m_crd = we ? rd : 5'd0; m_cwd = wd;
    end
    @(negedge clk);
    check_regs(tag);
  endtask

  initial begin
    logic [31:0] r_alu;
    logic        r_ctl;
    clk = 0; rst = 1; n_vec = 0; n_fail = 0;
    bus.i_ctrl_valid = 0; bus.i_ctrl_bubble = 0; bus.i_ctrl_wb_en = 0;
    bus.i_ctrl_mem_read = 0; bus.i_ctrl_mispred = 0; bus.i_ctrl_is_control = 0;
    bus.i_stall = 0; bus.i_cnt_clr = 0; bus.i_ctrl_funct3 = 0; bus.i_rd = 0;
    bus.i_pc = 0; bus.i_alu_result = 0; bus.i_rdata = 0;
    model_zero();
    #8;
    check_regs("reset");
    @(negedge clk);
    rst = 0;
    check("reset.first_cycle", bus.o_cycle, 64'd0);

    // Loads from the directed plan, each also checked against a fixed value
    apply("lb_off3", 1,0,1,1,0,0,0,0, 3'b000, 5'd5, 32'h100, 32'h1003, 32'h80FF_1234);
    check("lb_off3.const", 64'(bus.o_rf_wdata), 64'h0000_0000_FFFF_FF80);
    apply("lbu_off3", 1,0,1,1,0,0,0,0, 3'b100, 5'd5, 32'h104, 32'h1003, 32'h80FF_1234);
    check("lbu_off3.const", 64'(bus.o_rf_wdata), 64'h0000_0000_0000_0080);
    apply("lh_off2", 1,0,1,1,0,0,0,0, 3'b001, 5'd6, 32'h108, 32'h1002, 32'h8001_7FFF);
    check("lh_off2.const", 64'(bus.o_rf_wdata), 64'h0000_0000_FFFF_8001);
    apply("lw_off3", 1,0,1,1,0,0,0,0, 3'b010, 5'd7, 32'h10C, 32'h1003, 32'hDEAD_BEEF);
    check("lw_off3.const", 64'(bus.o_rf_wdata), 64'h0000_0000_DEAD_BEEF);
    apply("rsvd_f3", 1,0,1,1,0,0,0,0, 3'b111, 5'd8, 32'h110, 32'h1001, 32'h1234_5678);

    // ALU write to x0: no write, still retires
    apply("alu_x0", 1,0,1,0,0,0,0,0, 3'b000, 5'd0, 32'h114, 32'h5555_AAAA, 32'h0);
    check("alu_x0.commit_rd", 64'(bus.o_commit_rd), 64'd0);

    // Branch held for two stalled cycles, then two more branches
    apply("br1_stall_a", 1,0,0,0,0,1,1,0, 3'b000, 5'd0, 32'h200, 32'h0, 32'h0);
    apply("br1_stall_b", 1,0,0,0,0,1,1,0, 3'b000, 5'd0, 32'h200, 32'h0, 32'h0);
    apply("br1_go", 1,0,0,0,0,1,0,0, 3'b000, 5'd0, 32'h200, 32'h0, 32'h0);
    apply("br2_misp", 1,0,0,0,1,1,0,0, 3'b000, 5'd0, 32'h204, 32'h0, 32'h0);
    apply("br3", 1,0,0,0,0,1,0,0, 3'b000, 5'd0, 32'h208, 32'h0, 32'h0);
    check("branches.ctrl_cnt", 64'(bus.o_ctrl_cnt), 64'd3);
    check("branches.mispred_cnt", 64'(bus.o_mispred_cnt), 64'd1);

    apply("stalled_write", 1,0,1,0,0,0,1,0, 3'b000, 5'd9, 32'h20C, 32'h77, 32'h0);
    apply("bubble", 1,1,1,0,0,0,0,0, 3'b000, 5'd9, 32'h210, 32'h99, 32'h0);
    apply("invalid", 0,0,1,0,0,0,0,0, 3'b000, 5'd9, 32'h214, 32'h99, 32'h0);
    apply("misp_no_ctrl", 1,0,0,0,1,0,0,0, 3'b000, 5'd0, 32'h218, 32'h0, 32'h0);

    apply("clr_with_retire", 1,0,1,0,1,1,0,1, 3'b000, 5'd3, 32'h21C, 32'h42, 32'h0);
    check("clr.cycle_zero", bus.o_cycle, 64'd0);
    apply("after_clr", 0,0,0,0,0,0,0,0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);

    // Instret wrap: preset to all ones, then retire one instruction
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    check("preset.instret", bus.o_instret, m_instret);
    @(negedge clk);
    m_cycle++;
    m_cv = 0;
    apply("wrap", 1,0,1,0,0,0,0,0, 3'b000, 5'd4, 32'h300, 32'h1, 32'h0);
    check("wrap.instret_zero", bus.o_instret, 64'd0);

    for (int i = 0; i < 150; i++) begin
      r_alu = $urandom;
      r_ctl = ($urandom_range(0, 3) == 0);
      apply("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            r_ctl && ($urandom_range(0, 2) == 0), r_ctl,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 40) == 0),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom, r_alu, $urandom);
    end

    // Asynchronous reset between edges with a retiring instruction presented
    bus.i_ctrl_valid = 1; bus.i_ctrl_wb_en = 1; bus.i_rd = 5'd10;
    bus.i_stall = 0; bus.i_cnt_clr = 0; bus.i_alu_result = 32'hABCD;
    #2;
    rst = 1;
    #1;
    model_zero();
    check_regs("async_reset");
    @(negedge clk);
    rst = 0;
    check_regs("post_reset");
    apply("post_reset_retire", 1,0,1,0,0,0,0,0, 3'b000, 5'd11, 32'h400, 32'h5, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
